// File: rtl/serial_tx.sv
// serial_tx: frame-based serial transmitter (start bit, DATA_W data bits
// LSB first, stop bit), each bit held CLKS_PER_BIT clock cycles.
//
// Ports:
//   i_clk     clock, all state updates on its rising edge
//   i_rst     synchronous active-high reset, priority over everything
//   i_enable  block enable; 0 aborts any frame and holds the block idle
//   i_valid   request to transmit i_data
//   i_data    word to send, sampled only on acceptance
//   o_ready   block can accept a word this cycle (combinational)
//   o_tx      registered serial line, idles high
//   o_busy    frame in progress
//   o_done    one-cycle pulse in the first idle cycle after a frame
module serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic              tx_nxt, busy_nxt, done_nxt;
  logic              bit_end;

  assign o_ready = (state == IDLE) && i_enable && !i_rst;
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      o_tx   <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      sh     <= sh_nxt;
      o_tx   <= tx_nxt;
      o_busy <= busy_nxt;
      o_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    tx_nxt    = o_tx;
    busy_nxt  = o_busy;
    done_nxt  = 1'b0;
    if (!i_enable) begin
      // Abort: back to idle line, no done pulse for the dropped frame.
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      tx_nxt    = 1'b1;
      busy_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tx_nxt = 1'b1;
          if (i_valid) begin
            state_nxt = START;
            sh_nxt    = i_data;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            tx_nxt    = 1'b0;
            busy_nxt  = 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
            tx_nxt    = sh[0];
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_nxt = '0;
            if (idx == IDX_LAST) begin
              state_nxt = STOP;
              idx_nxt   = '0;
              tx_nxt    = 1'b1;
            end else begin
              // Present the next bit while shifting it into position 0.
              idx_nxt = idx + IW'(1);
              sh_nxt  = sh >> 1;
              tx_nxt  = sh[1];
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;
  localparam int CPB = 4;
  localparam int DW  = 8;
  localparam int FL  = (DW + 2) * CPB;  // line cycles per frame

  logic          i_clk = 1'b0;
  logic          i_rst, i_enable, i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready, o_tx, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_valid(i_valid),
    .i_data(i_data), .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // Reference: pos = cycles since acceptance (1..FL on the line, FL+1 is
  // the done/gap cycle), 0 = idle with nothing pending.
  int            pos = 0;
  logic [DW-1:0] md  = '0;

  always @(posedge i_clk) begin
    if (i_rst || !i_enable) pos <= 0;
    else if ((pos == 0 || pos == FL + 1) && i_valid) begin
      pos <= 1;
      md  <= i_data;
    end else if (pos >= 1 && pos <= FL) pos <= pos + 1;
    else pos <= 0;
  end

  function automatic logic exp_tx();
    int b;
    if (pos < 1 || pos > FL) return 1'b1;
    b = (pos - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return md[b-1];
    return 1'b1;
  endfunction

  // {tx, busy, done, ready}
  function automatic logic [3:0] exp_vec();
    logic rdy;
    rdy = (pos == 0 || pos == FL + 1) && i_enable && !i_rst;
    return {exp_tx(), (pos >= 1 && pos <= FL), (pos == FL + 1), rdy};
  endfunction

  task automatic test_reset();
    i_rst = 1; i_enable = 1; i_valid = 1; i_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checks++;
      if ({o_tx, o_busy, o_done, o_ready} !== 4'b1000) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b exp 1000", i, {o_tx, o_busy, o_done, o_ready});
      end
    end
    i_rst = 0; i_valid = 0;
    @(negedge i_clk);
  endtask

  task automatic test_frame_a5();
    logic [DW-1:0] cap = '0;
    int start_c = -1, done_c = -1;
    i_valid = 1; i_data = 8'hA5;
    for (int i = 1; i <= FL + 3; i++) begin
      @(negedge i_clk);
      checks++;
      if ({o_tx, o_busy, o_done, o_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL a5_line cyc %0d: got %b exp %b", i, {o_tx, o_busy, o_done, o_ready}, exp_vec());
      end
      if (o_busy && start_c < 0) start_c = i;
      if (o_done && done_c < 0) done_c = i;
      if ((i - 1) % CPB == 2 && (i - 1) / CPB >= 1 && (i - 1) / CPB <= DW)
        cap[(i - 1) / CPB - 1] = o_tx;
      i_valid = 0; i_data = DW'($urandom);
    end
    checks++;
    if (cap !== 8'hA5) begin
      errors++;
      $display("FAIL a5_bits: got %h exp a5", cap);
    end
    checks++;
    if (done_c - start_c !== FL) begin
      errors++;
      $display("FAIL a5_latency: got %0d exp %0d", done_c - start_c, FL);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0, s1 = -1, s2 = -1;
    logic pb = 0;
    i_valid = 1; i_data = 8'h00;
    for (int i = 1; i <= 2 * FL + 6; i++) begin
      @(negedge i_clk);
      checks++;
      if ({o_tx, o_busy, o_done, o_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_line cyc %0d: got %b exp %b", i, {o_tx, o_busy, o_done, o_ready}, exp_vec());
      end
      if (o_done) dones++;
      if (o_busy && !pb) begin
        if (s1 < 0) s1 = i; else if (s2 < 0) s2 = i;
      end
      pb = o_busy;
      if (i == 1) i_data = 8'hFF;
      if (i == FL + 10) i_valid = 0;
    end
    checks++;
    if (dones !== 2) begin
      errors++;
      $display("FAIL b2b_dones: got %0d exp 2", dones);
    end
    checks++;
    if (s2 - s1 !== FL + 1) begin
      errors++;
      $display("FAIL b2b_pitch: got %0d exp %0d", s2 - s1, FL + 1);
    end
  endtask

  task automatic test_data_change();
    logic [DW-1:0] cap = '0;
    i_valid = 1; i_data = 8'h3C;
    for (int i = 1; i <= FL + 3; i++) begin
      @(negedge i_clk);
      checks++;
      if ({o_tx, o_busy, o_done, o_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL chg_line cyc %0d: got %b exp %b", i, {o_tx, o_busy, o_done, o_ready}, exp_vec());
      end
      if ((i - 1) % CPB == 2 && (i - 1) / CPB >= 1 && (i - 1) / CPB <= DW)
        cap[(i - 1) / CPB - 1] = o_tx;
      if (i == 1) i_valid = 0;
      if (i == 5) begin i_data = 8'hC3; i_valid = 1; end
      if (i == 12) i_valid = 0;
    end
    checks++;
    if (cap !== 8'h3C) begin
      errors++;
      $display("FAIL chg_bits: got %h exp 3c", cap);
    end
  endtask

  task automatic test_enable_drop();
    int dones = 0;
    i_valid = 1; i_data = DW'($urandom);
    for (int i = 1; i <= FL + 20; i++) begin
      @(negedge i_clk);
      checks++;
      if ({o_tx, o_busy, o_done, o_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL en_line cyc %0d: got %b exp %b", i, {o_tx, o_busy, o_done, o_ready}, exp_vec());
      end
      if (o_done) dones++;
      if (i == 19) begin
        checks++;
        if ({o_tx, o_busy} !== 2'b10) begin
          errors++;
          $display("FAIL en_abort: got tx/busy %b exp 10", {o_tx, o_busy});
        end
      end
      if (i == 1) i_valid = 0;
      if (i == 2 + 4 * CPB) i_enable = 0;  // inside data bit 3
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL en_no_done: got %0d exp 0", dones);
    end
    i_enable = 1; i_valid = 1; i_data = DW'($urandom);
    for (int i = 1; i <= FL + 3; i++) begin
      @(negedge i_clk);
      checks++;
      if ({o_tx, o_busy, o_done, o_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL en_resume cyc %0d: got %b exp %b", i, {o_tx, o_busy, o_done, o_ready}, exp_vec());
      end
      if (o_done) dones++;
      i_valid = 0;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL en_resume_done: got %0d exp 1", dones);
    end
  endtask

  task automatic test_rst_stop();
    int dones = 0;
    i_valid = 1; i_data = DW'($urandom);
    for (int i = 1; i <= FL + 10; i++) begin
      @(negedge i_clk);
      checks++;
      if ({o_tx, o_busy, o_done, o_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL rst_line cyc %0d: got %b exp %b", i, {o_tx, o_busy, o_done, o_ready}, exp_vec());
      end
      if (o_done) dones++;
      if (i == FL - 1) begin
        checks++;
        if ({o_tx, o_busy, o_ready} !== 3'b100) begin
          errors++;
          $display("FAIL rst_during: got %b exp 100", {o_tx, o_busy, o_ready});
        end
      end
      if (i == 1) i_valid = 0;
      if (i == FL - 2) i_rst = 1;  // inside stop bit
      if (i == FL + 1) i_rst = 0;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d exp 0", dones);
    end
  endtask

  task automatic test_disabled_valid();
    i_enable = 0; i_valid = 1; i_data = DW'($urandom);
    for (int i = 1; i <= 20; i++) begin
      @(negedge i_clk);
      checks++;
      if ({o_tx, o_busy, o_done, o_ready} !== 4'b1000) begin
        errors++;
        $display("FAIL dis_valid cyc %0d: got %b exp 1000", i, {o_tx, o_busy, o_done, o_ready});
      end
    end
    i_enable = 1; i_valid = 0;
    @(negedge i_clk);
  endtask

  task automatic test_random();
    for (int i = 1; i <= 600; i++) begin
      @(negedge i_clk);
      checks++;
      if ({o_tx, o_busy, o_done, o_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL rand cyc %0d: got %b exp %b", i, {o_tx, o_busy, o_done, o_ready}, exp_vec());
      end
      i_enable = ($urandom_range(0, 149) != 0);
      i_rst    = ($urandom_range(0, 249) == 0);
      i_valid  = $urandom_range(0, 1);
      i_data   = DW'($urandom);
    end
    i_rst = 0; i_enable = 1; i_valid = 0;
  endtask

  initial begin
    i_rst = 1; i_enable = 1; i_valid = 0; i_data = '0;
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_data_change();
    test_enable_drop();
    test_rst_stop();
    test_disabled_valid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, SHALL set clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_W, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-003 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of i_clk.
REQ-005 i_enable  input  1  SHALL be the block enable; 0 forces idle.
REQ-006 i_valid  input  1  SHALL request transmission of i_data.
REQ-007 i_data  input  DATA_W  SHALL carry the word to send, sampled only on acceptance.
REQ-008 o_ready  output  1  SHALL indicate the block can accept a word this cycle.
REQ-009 o_tx  output  1  SHALL be the registered serial line; idle level 1.
REQ-010 o_busy  output  1  SHALL be 1 while a frame is in progress.
REQ-011 o_done  output  1  SHALL pulse high for one cycle when a frame completes.

Function
REQ-012 Frame format SHALL be: one start bit (0), DATA_W data bits LSB first, one stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 o_ready SHALL equal (state == IDLE) AND i_enable AND NOT i_rst, combinationally.
REQ-015 Acceptance SHALL occur at a rising edge where i_valid = 1 and o_ready = 1; i_data SHALL be latched into an internal shift register at that edge.
REQ-016 IDLE -> START on acceptance; o_tx SHALL be 0 and o_busy 1 from the cycle after acceptance.
REQ-017 START -> DATA after CLKS_PER_BIT cycles; DATA SHALL output bit 0 first and shift right once per bit period.
REQ-018 DATA -> STOP after DATA_W bit periods; STOP SHALL drive o_tx = 1 for CLKS_PER_BIT cycles.
REQ-019 STOP -> IDLE at end of stop bit; o_done SHALL be 1 during the first IDLE cycle only; o_busy SHALL be 0 in that cycle.
REQ-020 Latency: first start-bit cycle SHALL be 1 cycle after acceptance; o_done SHALL assert (DATA_W+2)*CLKS_PER_BIT cycles after the first start-bit cycle.
REQ-021 Back-to-back: with i_valid held at 1, the next acceptance SHALL occur in the o_done cycle, giving a frame pitch of (DATA_W+2)*CLKS_PER_BIT+1 cycles with o_tx = 1 in the gap cycle.
REQ-022 i_valid and i_data changes while o_busy = 1 SHALL have no effect on the current frame and SHALL not be queued.
REQ-023 Bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload to 0 at every bit boundary; bit index counter SHALL wrap only via state change, never silently.
REQ-024 i_enable = 0 in any state SHALL, at the next edge, force state IDLE, o_tx = 1, o_busy = 0, o_done = 0, and clear both counters; the aborted frame SHALL not produce o_done.
REQ-025 i_enable = 0 and i_valid = 1 at the same edge SHALL not start a frame.

Reset
REQ-026 i_rst = 1 SHALL take priority over i_enable and i_valid at every edge.
REQ-027 After reset: state IDLE, o_tx = 1, o_busy = 0, o_done = 0, counters and shift register 0; o_ready SHALL be 0 while i_rst = 1.
REQ-028 Reset asserted mid-frame SHALL abort it identically to REQ-024 with o_tx = 1 at the next edge.

Verification (CLKS_PER_BIT = 4, DATA_W = 8)
REQ-029 Reset, enable = 1, send 0xA5 -> o_tx after start reads 1,0,1,0,0,1,0,1 then stop 1, each 4 cycles; o_done pulses 40 cycles after first start cycle.
REQ-030 i_valid held high with 0x00 then 0xFF -> two frames, pitch 41 cycles, one high gap cycle, two o_done pulses.
REQ-031 i_data changed from 0x3C to 0xC3 at cycle 5 of a frame -> transmitted bits still match 0x3C.
REQ-032 i_enable dropped during data bit 3 -> o_tx = 1, o_busy = 0 next cycle; no o_done; new frame accepted after re-enable.
REQ-033 i_rst pulsed during stop bit -> o_tx = 1, o_busy = 0, o_ready = 0 during reset, no o_done.
REQ-034 i_valid = 1 with i_enable = 0 for 20 cycles -> o_tx stays 1, o_ready = 0, no frame.
